// File: rtl/pool2x2_stream.sv
// pool2x2_stream
// 2x2 / stride-2 pooling stage for the raster-ordered conv output stream.
// All CH channels are processed in lockstep. The stage runs in max or average
// mode, and the mode is captured at each frame origin. Each pooled pixel is
// emitted as a one-cycle pulse. Each finished pooled row is also presented
// as a packed line register for the following linear stage.
module pool2x2_stream #(
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic                         sof,
  input  logic                         mode,
  input  logic [CH*DW-1:0]             conv_in,
  output logic                         pool_vld,
  output logic [CH*DW-1:0]             pool_out,
  output logic [CH*(IMG_W/2)*DW-1:0]   pool_lin,
  output logic                         line_vld,
  output logic                         frame_done
);

  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  // The column counter keeps at least two bits so that a pooled-slot index
  // (col >> 1) always has at least one bit.
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int SW = CW - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(2 * OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(2 * OH - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             mode_q;

  logic [CW-1:0]    eff_col;
  logic [RW-1:0]    eff_row;
  logic [SW-1:0]    slot;
  logic             col_odd;
  logic             row_odd;
  logic             at_origin;
  logic             cur_mode;
  logic             emit;
  logic             row_end;
  logic             frame_end;
  logic [CH*DW-1:0] pooled_all;

  // Resolve the position of the current beat. A qualified sof forces the
  // origin. The beat at the origin uses the freshly presented mode bit, and
  // every other beat uses the mode captured at the origin.
  always_comb begin
    eff_col   = sof ? '0 : col;
    eff_row   = sof ? '0 : row;
    slot      = eff_col[CW-1:1];
    col_odd   = eff_col[0];
    row_odd   = eff_row[0];
    at_origin = (eff_col == '0) && (eff_row == '0);
    cur_mode  = at_origin ? mode : mode_q;
    emit      = in_vld && col_odd && row_odd;
    row_end   = (eff_col == COL_LAST);
    frame_end = row_end && (eff_row == ROW_LAST);
  end

  // Advance the raster position and capture the mode on every valid beat.
  // Wrapping past the last row starts the next frame implicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (in_vld) begin
      mode_q <= cur_mode;
      if (row_end) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0]   px;
    logic [DW-1:0]   stash;
    logic [DW-1:0]   h_max;
    logic [DW:0]     h;
    logic [DW:0]     b_ent;
    logic [DW-1:0]   v_max;
    logic [DW+1:0]   v_sum;
    logic [DW-1:0]   pooled;
    logic [DW:0]     lbuf [OW];

    // Form the horizontal pair value from the stash and the current pixel.
    // Then combine it with the matching line-buffer entry from the even row
    // above. The average path carries two extra bits, so the sum of four
    // pixels cannot overflow before the final divide by four.
    always_comb begin
      px     = conv_in[c*DW +: DW];
      h_max  = (stash > px) ? stash : px;
      h      = cur_mode ? ({1'b0, stash} + {1'b0, px}) : {1'b0, h_max};
      b_ent  = lbuf[slot];
      v_max  = (h[DW-1:0] > b_ent[DW-1:0]) ? h[DW-1:0] : b_ent[DW-1:0];
      v_sum  = {1'b0, h} + {1'b0, b_ent};
      pooled = cur_mode ? DW'(v_sum >> 2) : v_max;
    end

    assign pooled_all[c*DW +: DW] = pooled;

    // Hold even-column pixels in the stash. Park even-row pair values in the
    // line buffer until the odd row beneath them arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        stash <= '0;
        for (int i = 0; i < OW; i++) begin
          lbuf[i] <= '0;
        end
      end else if (in_vld) begin
        if (!col_odd) begin
          stash <= px;
        end else if (!row_odd) begin
          lbuf[slot] <= h;
        end
      end
    end
  end

  // Register the pooled pixel and the pulses. Drop the pixel into its slot of
  // the line register, so the register holds one complete pooled row at each
  // line_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool_vld   <= 1'b0;
      line_vld   <= 1'b0;
      frame_done <= 1'b0;
      pool_out   <= '0;
      pool_lin   <= '0;
    end else begin
      pool_vld   <= emit;
      line_vld   <= emit && row_end;
      frame_done <= emit && frame_end;
      if (emit) begin
        pool_out <= pooled_all;
        for (int c = 0; c < CH; c++) begin
          pool_lin[(c*OW + int'(slot))*DW +: DW] <= pooled_all[c*DW +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream with the default 6x6, 3-channel, 8-bit configuration.
module tb_pool2x2_stream;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int OW    = IMG_W / 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_vld = 1'b0;
  logic                 sof = 1'b0;
  logic                 mode = 1'b0;
  logic [CH*DW-1:0]     conv_in = '0;
  logic                 pool_vld;
  logic [CH*DW-1:0]     pool_out;
  logic [CH*OW*DW-1:0]  pool_lin;
  logic                 line_vld;
  logic                 frame_done;

  pool2x2_stream #(.DW(DW), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .sof        (sof),
    .mode       (mode),
    .conv_in    (conv_in),
    .pool_vld   (pool_vld),
    .pool_out   (pool_out),
    .pool_lin   (pool_lin),
    .line_vld   (line_vld),
    .frame_done (frame_done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Hand-computed pooled ch0 values: ramp pattern 10r+k, falling pattern 100-10r-k
  int ramp_exp [9] = '{11, 13, 15, 31, 33, 35, 51, 53, 55};
  int down_exp [9] = '{100, 98, 96, 80, 78, 76, 60, 58, 56};

  int got_c0[$];
  int got_c2[$];
  int got_line[$];
  int got_frame[$];
  logic [CH*OW*DW-1:0] got_lin[$];
  int line_cnt  = 0;
  int frame_cnt = 0;

  int exp_c0[$];
  int exp_c2[$];
  int exp_line[$];
  int exp_frame[$];

  logic [CH*OW*DW-1:0] snap;

  // Record every output pulse on the falling edge, half a cycle after it was registered
  always @(negedge clk) begin
    if (pool_vld === 1'b1) begin
      got_c0.push_back(int'(pool_out[0 +: DW]));
      got_c2.push_back(int'(pool_out[2*DW +: DW]));
      got_line.push_back(int'(line_vld));
      got_frame.push_back(int'(frame_done));
    end
    if (line_vld === 1'b1) begin
      line_cnt++;
      got_lin.push_back(pool_lin);
    end
    if (frame_done === 1'b1) begin
      frame_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [CH*DW-1:0] make_pixel(input int pat, input int r, input int k);
    logic [CH*DW-1:0] d;
    d = '0;
    for (int c = 0; c < CH; c++) begin
      case (pat)
        0:       d[c*DW +: DW] = DW'(10*r + k + c);
        1:       d[c*DW +: DW] = (r == 1 && k == 1) ? 8'h00 : 8'hFF;
        default: d[c*DW +: DW] = DW'(100 - 10*r - k + c);
      endcase
    end
    return d;
  endfunction

  task automatic applyStimulus(input logic v, input logic s, input logic m, input logic [CH*DW-1:0] d);
    @(posedge clk);
    #1;
    in_vld  = v;
    sof     = s;
    mode    = m;
    conv_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Send the first nbeats pixels of a frame in raster order. Mode m0 is presented
  // on the first beat and m1 on every later one. Idle gaps carry garbage sof/mode/data.
  task automatic send_frame(input int pat, input logic m0, input logic m1,
                            input bit use_sof, input bit gaps, input int nbeats);
    int beat;
    beat = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int k = 0; k < IMG_W; k++) begin
        if (beat < nbeats) begin
          if (gaps) begin
            repeat ($urandom_range(0, 2))
              applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), CH*DW'($urandom));
          end
          applyStimulus(1'b1, use_sof && (beat == 0), (beat == 0) ? m0 : m1, make_pixel(pat, r, k));
          beat++;
        end
      end
    end
  endtask

  task automatic expect_px(input int v0, input int v2, input int ln, input int fr);
    exp_c0.push_back(v0);
    exp_c2.push_back(v2);
    exp_line.push_back(ln);
    exp_frame.push_back(fr);
  endtask

  task automatic expect_frame(input int pat);
    for (int i = 0; i < 9; i++) begin
      case (pat)
        0:       expect_px(ramp_exp[i], ramp_exp[i] + 2, int'(i % 3 == 2), int'(i == 8));
        1:       expect_px((i == 0) ? 191 : 255, (i == 0) ? 191 : 255, int'(i % 3 == 2), int'(i == 8));
        default: expect_px(down_exp[i], down_exp[i] + 2, int'(i % 3 == 2), int'(i == 8));
      endcase
    end
  endtask

  task automatic clear_all();
    got_c0.delete(); got_c2.delete(); got_line.delete(); got_frame.delete(); got_lin.delete();
    exp_c0.delete(); exp_c2.delete(); exp_line.delete(); exp_frame.delete();
    line_cnt  = 0;
    frame_cnt = 0;
  endtask

  task automatic verifyRun(input string name, input int exp_lines, input int exp_frames);
    checkOutput({name, " pool_vld count"}, got_c0.size(), exp_c0.size());
    for (int i = 0; i < exp_c0.size(); i++) begin
      if (i < got_c0.size()) begin
        checkOutput($sformatf("%s px%0d ch0", name, i), got_c0[i], exp_c0[i]);
        checkOutput($sformatf("%s px%0d ch2", name, i), got_c2[i], exp_c2[i]);
        checkOutput($sformatf("%s px%0d line_vld", name, i), got_line[i], exp_line[i]);
        checkOutput($sformatf("%s px%0d frame_done", name, i), got_frame[i], exp_frame[i]);
      end
    end
    checkOutput({name, " line_vld count"}, line_cnt, exp_lines);
    checkOutput({name, " frame_done count"}, frame_cnt, exp_frames);
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pool_vld", pool_vld, 0);
    checkOutput("reset line_vld", line_vld, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset pool_out", pool_out, 0);
    checkOutput("reset pool_lin", pool_lin, 0);
    rst = 1'b0;

    // Max mode, ramp pattern, no gaps
    clear_all();
    send_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 36);
    idle(2);
    expect_frame(0);
    verifyRun("max", 3, 1);
    checkOutput("max line snapshots", got_lin.size(), 3);
    if (got_lin.size() >= 3) begin
      snap = got_lin[0];
      checkOutput("lin row0 ch0 s0", snap[0*DW +: DW], 11);
      checkOutput("lin row0 ch0 s1", snap[1*DW +: DW], 13);
      checkOutput("lin row0 ch0 s2", snap[2*DW +: DW], 15);
      checkOutput("lin row0 ch1 s2", snap[(1*OW + 2)*DW +: DW], 16);
      snap = got_lin[2];
      checkOutput("lin row2 ch2 s0", snap[(2*OW + 0)*DW +: DW], 53);
      checkOutput("lin row2 ch0 s2", snap[2*DW +: DW], 55);
    end

    // Average mode, all-255 frame with a single zero pixel at (1,1)
    clear_all();
    send_frame(1, 1'b1, 1'b1, 1'b0, 1'b0, 36);
    idle(2);
    expect_frame(1);
    verifyRun("avg", 3, 1);

    // Same max frame with random idle gaps
    clear_all();
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, 36);
    idle(2);
    expect_frame(0);
    verifyRun("gaps", 3, 1);

    // Falling pattern: the maximum sits in the stash and the line buffer
    clear_all();
    send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 36);
    idle(2);
    expect_frame(2);
    verifyRun("down", 3, 1);

    // sof at pixel (3,2) aborts the frame, and the partial pooled row yields no line_vld
    clear_all();
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    send_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, 36);
    idle(2);
    expect_px(11, 13, 0, 0);
    expect_px(13, 15, 0, 0);
    expect_px(15, 17, 1, 0);
    expect_px(31, 33, 0, 0);
    expect_frame(0);
    verifyRun("sof", 4, 1);

    // Reset after 20 beats. Reset wins over in_vld/sof, and the next frame starts without sof.
    clear_all();
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_vld = 1'b1;
    sof = 1'b1;
    conv_in = make_pixel(0, 5, 5);
    @(posedge clk);
    #1;
    checkOutput("rst pool_vld", pool_vld, 0);
    checkOutput("rst line_vld", line_vld, 0);
    checkOutput("rst frame_done", frame_done, 0);
    checkOutput("rst pool_out", pool_out, 0);
    checkOutput("rst pool_lin", pool_lin, 0);
    rst = 1'b0;
    in_vld = 1'b0;
    sof = 1'b0;
    expect_px(11, 13, 0, 0);
    expect_px(13, 15, 0, 0);
    expect_px(15, 17, 1, 0);
    expect_px(31, 33, 0, 0);
    verifyRun("pre-rst", 1, 0);
    clear_all();
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 36);
    idle(2);
    expect_frame(0);
    verifyRun("post-rst", 3, 1);

    // Mode toggled mid-frame, then back-to-back frames in different modes
    clear_all();
    send_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, 36);
    send_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, 36);
    idle(2);
    expect_frame(0);
    expect_frame(1);
    verifyRun("modes", 6, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
